// File: rtl/mem_stream_pkg.sv
// Shared types, constants and helpers for the memory stream reader.
package mem_stream_pkg;

  localparam int ADDR_W     = 16;
  localparam int MEM_RD_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Number of set bits in the in-flight tag pipeline.
  function automatic logic [7:0] ones_count(input logic [MEM_RD_LAT-1:0] v);
    logic [7:0] n;
    n = 8'd0;
    for (int i = 0; i < MEM_RD_LAT; i++) begin
      n = n + {7'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and clear.
module stream_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Qualify requests against current occupancy.
  always_comb begin
    pop_ok_s  = pop && (count_r != {(AW+1){1'b0}});
    push_ok_s = push && ((count_r != FULL) || pop_ok_s);
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (push_ok_s && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign pop_data = (count_r != {(AW+1){1'b0}}) ? mem_r[rd_ptr_r] : {WIDTH{1'b0}};
  assign count    = count_r;

endmodule

// File: rtl/mem_stream_reader.sv
// Streams LENGTH words from a registered-read memory starting at BASE as a
// valid/ready stream, with optional endless looping and abort/flush.
module mem_stream_reader
  import mem_stream_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       base_addr,
  input  logic [15:0]       length,
  input  logic              loop,
  input  logic              abort,
  output logic [15:0]       mem_rd_addr,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int CW = $clog2(FIFO_DEPTH);

  state_e              state_r;
  state_e              state_nx_s;
  logic [ADDR_W-1:0]   base_r;
  logic [ADDR_W-1:0]   len_r;
  logic                loop_r;
  logic [ADDR_W-1:0]   issue_cnt_r;
  logic [ADDR_W-1:0]   acc_cnt_r;
  logic [MEM_RD_LAT-1:0] tag_r;
  logic [CW:0]         fifo_count_s;
  logic [CW+1:0]       occ_s;
  logic                start_acc_s;
  logic                issue_s;
  logic [ADDR_W-1:0]   issue_addr_s;
  logic [ADDR_W-1:0]   issue_cnt_nx_s;
  logic                push_s;
  logic                pop_s;
  logic                clear_s;
  logic                last_xfer_s;
  logic                busy_nx_s;
  logic                done_nx_s;

  // Credit, transfer and issue decisions.
  always_comb begin
    start_acc_s    = (state_r == ST_IDLE) && start;
    occ_s          = (CW+2)'(fifo_count_s) + (CW+2)'(ones_count(tag_r));
    pop_s          = out_valid && out_ready;
    last_xfer_s    = pop_s && !loop_r && (acc_cnt_r == len_r - 16'd1);
    push_s         = tag_r[MEM_RD_LAT-1] && (state_r == ST_RUN) && !abort;
    clear_s        = (state_r == ST_RUN) && abort;
    issue_s        = 1'b0;
    issue_addr_s   = mem_rd_addr;
    issue_cnt_nx_s = issue_cnt_r;
    if (start_acc_s) begin
      issue_s        = (length != 16'd0);
      issue_addr_s   = base_addr;
      issue_cnt_nx_s = (loop && (length == 16'd1)) ? 16'd0 : 16'd1;
    end else if ((state_r == ST_RUN) && !abort && (occ_s < (CW+2)'(FIFO_DEPTH)) &&
                 (loop_r || (issue_cnt_r < len_r))) begin
      issue_s        = 1'b1;
      issue_addr_s   = base_r + issue_cnt_r;
      issue_cnt_nx_s = (loop_r && (issue_cnt_r == len_r - 16'd1)) ? 16'd0 : issue_cnt_r + 16'd1;
    end else begin
      issue_s        = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nx_s = (length == 16'd0) ? ST_DONE : ST_RUN;
        else       state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (abort)            state_nx_s = ST_FLUSH;
        else if (last_xfer_s) state_nx_s = ST_DONE;
        else                  state_nx_s = ST_RUN;
      end
      ST_FLUSH: begin
        if (tag_r == {MEM_RD_LAT{1'b0}}) state_nx_s = ST_IDLE;
        else                             state_nx_s = ST_FLUSH;
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the upcoming state so they register cleanly.
  always_comb begin
    busy_nx_s = (state_nx_s != ST_IDLE);
    done_nx_s = (state_nx_s == ST_DONE);
  end

  // State and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy    <= busy_nx_s;
      done    <= done_nx_s;
    end
  end

  // Transfer parameters captured on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r <= 16'h0000;
      len_r  <= 16'h0000;
      loop_r <= 1'b0;
    end else if (start_acc_s) begin
      base_r <= base_addr;
      len_r  <= length;
      loop_r <= loop;
    end
  end

  // Read issue: address register plus tag shift matching the memory latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_addr <= 16'h0000;
      issue_cnt_r <= 16'h0000;
      tag_r       <= {MEM_RD_LAT{1'b0}};
    end else begin
      tag_r <= {tag_r[MEM_RD_LAT-2:0], issue_s};
      if (issue_s) begin
        mem_rd_addr <= issue_addr_s;
        issue_cnt_r <= issue_cnt_nx_s;
      end
    end
  end

  // Completion is judged on accepted output words, not issued reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt_r <= 16'h0000;
    end else if (start_acc_s) begin
      acc_cnt_r <= 16'h0000;
    end else if (pop_s && (state_r == ST_RUN)) begin
      acc_cnt_r <= acc_cnt_r + 16'd1;
    end
  end

  stream_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear_s),
    .push      (push_s),
    .push_data (mem_rd_data),
    .pop       (pop_s),
    .pop_data  (out_data),
    .count     (fifo_count_s)
  );

  assign out_valid = (fifo_count_s != {(CW+1){1'b0}});

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed self-checking bench for mem_stream_reader with a 1-cycle registered memory model.
module tb_mem_stream_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] length;
  logic        loop;
  logic        abort;
  logic [15:0] mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] xfer_q[$];

  mem_stream_reader #(.WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .loop        (loop),
    .abort       (abort),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Memory model: mem[a] = a ^ 16'hA5A5, registered read.
  always @(posedge clk) mem_rd_data <= mem_rd_addr ^ 16'hA5A5;

  // Record every stream transfer.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) xfer_q.push_back(out_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [15:0] b, input logic [15:0] l, input logic lp);
    tick();
    start = 1'b1; base_addr = b; length = l; loop = lp;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic        stall;
    logic        done_seen;
    logic [15:0] last;

    rst_n = 1'b0; start = 1'b0; base_addr = 16'h0; length = 16'h0;
    loop = 1'b0; abort = 1'b0; out_ready = 1'b1;
    tick(); tick();
    check_eq("rst_addr",  {16'h0, mem_rd_addr}, 32'h0);
    check_eq("rst_valid", {31'h0, out_valid}, 32'h0);
    check_eq("rst_busy",  {31'h0, busy}, 32'h0);
    check_eq("rst_done",  {31'h0, done}, 32'h0);
    check_eq("rst_data",  {16'h0, out_data}, 32'h0);
    rst_n = 1'b1;

    // 1: base 0x0010, len 8, ready held high
    xfer_q.delete();
    launch(16'h0010, 16'd8, 1'b0);
    check_eq("t1_addr0", {16'h0, mem_rd_addr}, 32'h0010);
    check_eq("t1_busy",  {31'h0, busy}, 32'h1);
    check_eq("t1_v0",    {31'h0, out_valid}, 32'h0);
    tick();
    check_eq("t1_v1",    {31'h0, out_valid}, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check_eq("t1_valid", {31'h0, out_valid}, 32'h1);
      check_eq("t1_data",  {16'h0, out_data}, {16'h0, 16'(16'h0010 + i) ^ 16'hA5A5});
      check_eq("t1_nodone", {31'h0, done}, 32'h0);
      tick();
    end
    check_eq("t1_done",    {31'h0, done}, 32'h1);
    check_eq("t1_vlow",    {31'h0, out_valid}, 32'h0);
    check_eq("t1_count",   xfer_q.size(), 32'd8);
    tick();
    check_eq("t1_done_off", {31'h0, done}, 32'h0);
    check_eq("t1_idle",    {31'h0, busy}, 32'h0);

    // 2: zero length
    launch(16'h1234, 16'd0, 1'b0);
    check_eq("t2_done",  {31'h0, done}, 32'h1);
    check_eq("t2_busy",  {31'h0, busy}, 32'h1);
    check_eq("t2_addr",  {16'h0, mem_rd_addr}, 32'h0017);
    check_eq("t2_valid", {31'h0, out_valid}, 32'h0);
    tick();
    check_eq("t2_done_off", {31'h0, done}, 32'h0);
    check_eq("t2_idle",  {31'h0, busy}, 32'h0);
    check_eq("t2_valid2", {31'h0, out_valid}, 32'h0);

    // 3: address wrap at 0xFFFF
    launch(16'hFFFE, 16'd4, 1'b0);
    check_eq("t3_a0", {16'h0, mem_rd_addr}, 32'hFFFE);
    tick();
    check_eq("t3_a1", {16'h0, mem_rd_addr}, 32'hFFFF);
    tick();
    check_eq("t3_a2", {16'h0, mem_rd_addr}, 32'h0000);
    check_eq("t3_d0", {16'h0, out_data}, 32'h5A5B);
    tick();
    check_eq("t3_a3", {16'h0, mem_rd_addr}, 32'h0001);
    check_eq("t3_d1", {16'h0, out_data}, 32'h5A5A);
    tick();
    check_eq("t3_d2", {16'h0, out_data}, 32'hA5A5);
    tick();
    check_eq("t3_d3", {16'h0, out_data}, 32'hA5A4);
    tick();
    check_eq("t3_done", {31'h0, done}, 32'h1);
    tick();

    // 4: random backpressure
    xfer_q.delete();
    out_ready = 1'($urandom_range(0, 1));
    launch(16'h0100, 16'd16, 1'b0);
    stall = 1'b0; done_seen = 1'b0; last = 16'h0;
    for (int c = 0; c < 300; c++) begin
      if (stall) begin
        check_eq("t4_hold_v", {31'h0, out_valid}, 32'h1);
        check_eq("t4_hold_d", {16'h0, out_data}, {16'h0, last});
      end
      if (done) begin
        done_seen = 1'b1;
        break;
      end
      out_ready = 1'($urandom_range(0, 1));
      stall = out_valid && !out_ready;
      last  = out_data;
      tick();
    end
    check_eq("t4_done_seen", {31'h0, done_seen}, 32'h1);
    out_ready = 1'b1;
    tick(); tick(); tick();
    check_eq("t4_count", xfer_q.size(), 32'd16);
    for (int k = 0; k < 16; k++) begin
      check_eq("t4_word", {16'h0, xfer_q[k]}, {16'h0, 16'(16'h0100 + k) ^ 16'hA5A5});
    end

    // 5: looping playback, then abort
    xfer_q.delete();
    launch(16'h0020, 16'd3, 1'b1);
    for (int c = 0; c < 50; c++) begin
      check_eq("t5_nodone", {31'h0, done}, 32'h0);
      if (xfer_q.size() >= 10) break;
      tick();
    end
    check_eq("t5_count", xfer_q.size(), 32'd10);
    out_ready = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0; out_ready = 1'b1;
    check_eq("t5_vlow",  {31'h0, out_valid}, 32'h0);
    check_eq("t5_busy_flush", {31'h0, busy}, 32'h1);
    for (int c = 0; c < 3; c++) begin
      if (!busy) break;
      tick();
    end
    check_eq("t5_busy_low", {31'h0, busy}, 32'h0);
    tick(); tick();
    check_eq("t5_no_stray", xfer_q.size(), 32'd10);
    check_eq("t5_vlow2", {31'h0, out_valid}, 32'h0);
    for (int k = 0; k < 10; k++) begin
      check_eq("t5_word", {16'h0, xfer_q[k]}, {16'h0, 16'(16'h0020 + (k % 3)) ^ 16'hA5A5});
    end

    // 6: reset mid-transfer, then a clean restart
    xfer_q.delete();
    launch(16'h0040, 16'd8, 1'b0);
    for (int c = 0; c < 20; c++) begin
      if (xfer_q.size() >= 3) break;
      tick();
    end
    check_eq("t6_pre", xfer_q.size(), 32'd3);
    rst_n = 1'b0;
    #1;
    check_eq("t6_addr",  {16'h0, mem_rd_addr}, 32'h0);
    check_eq("t6_valid", {31'h0, out_valid}, 32'h0);
    check_eq("t6_data",  {16'h0, out_data}, 32'h0);
    check_eq("t6_busy",  {31'h0, busy}, 32'h0);
    check_eq("t6_done",  {31'h0, done}, 32'h0);
    tick(); tick();
    rst_n = 1'b1;
    xfer_q.delete();
    launch(16'h0050, 16'd2, 1'b0);
    check_eq("t6_addr0", {16'h0, mem_rd_addr}, 32'h0050);
    tick(); tick();
    check_eq("t6_d0", {16'h0, out_data}, 32'hA5F5);
    tick();
    check_eq("t6_d1", {16'h0, out_data}, 32'hA5F4);
    tick();
    check_eq("t6_done2", {31'h0, done}, 32'h1);
    check_eq("t6_count", xfer_q.size(), 32'd2);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
